inst_mem: RTL and testbench

// Instruction-memory responder: the memory side of the CPU fetch port (rom_ce/rom_addr in, rom_data out).
// - Synchronous word-organised ROM image with 1-cycle registered read.
// - A byte-stream loader fills the array at run time; reads are suppressed while a load is in progress.
// - Sits beside the cpu top, between the program source (host/UART byte stream) and the IF stage.

---
 rtl/inst_mem_pkg.sv | 19 +
 rtl/inst_mem_if.sv | 46 ++++
 rtl/inst_mem_packer.sv | 47 ++++
 rtl/inst_mem.sv | 180 ++++++++++++++++++
 tb/tb_inst_mem.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/inst_mem_pkg.sv
// Shared constants and FSM encoding for the instruction-memory responder.
package inst_mem_pkg;

  localparam int unsigned INST_LEN = 32;
  localparam int unsigned ADDR_LEN = 32;
  localparam int unsigned BYTE_LEN = 8;

  // addi x0, x0, 0 -- harmless filler while the image is not readable
  localparam logic [INST_LEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StFlush = 3'd2,
    StFull  = 3'd3,
    StDone  = 3'd4
  } load_state_e;

endpackage

// File: rtl/inst_mem_if.sv
// Fetch port plus byte-stream loader port of the instruction memory.
// INST_MEM_MISALIGN_CHK_EN adds the misalign_o flag next to rom_data_o.
interface inst_mem_if #(
  parameter int unsigned DEPTH_LOG2 = 10
) ();
  import inst_mem_pkg::*;

  logic                  rom_ce_i;
  logic [ADDR_LEN-1:0]   rom_addr_i;
  logic [INST_LEN-1:0]   rom_data_o;
  logic                  load_start_i;
  logic                  load_valid_i;
  logic [BYTE_LEN-1:0]   load_byte_i;
  logic                  load_end_i;
  logic                  load_ready_o;
  logic                  load_active_o;
  logic                  load_done_o;
  logic                  load_err_o;
  logic [DEPTH_LOG2:0]   word_count_o;
`ifdef INST_MEM_MISALIGN_CHK_EN
  logic                  misalign_o;

  modport slave (
    input  rom_ce_i, rom_addr_i, load_start_i, load_valid_i, load_byte_i, load_end_i,
    output rom_data_o, load_ready_o, load_active_o, load_done_o, load_err_o, word_count_o,
    output misalign_o
  );

  modport master (
    output rom_ce_i, rom_addr_i, load_start_i, load_valid_i, load_byte_i, load_end_i,
    input  rom_data_o, load_ready_o, load_active_o, load_done_o, load_err_o, word_count_o,
    input  misalign_o
  );
`else
  modport slave (
    input  rom_ce_i, rom_addr_i, load_start_i, load_valid_i, load_byte_i, load_end_i,
    output rom_data_o, load_ready_o, load_active_o, load_done_o, load_err_o, word_count_o
  );

  modport master (
    output rom_ce_i, rom_addr_i, load_start_i, load_valid_i, load_byte_i, load_end_i,
    input  rom_data_o, load_ready_o, load_active_o, load_done_o, load_err_o, word_count_o
  );
`endif

endinterface

// File: rtl/inst_mem_packer.sv
// Assembles a little-endian byte stream into 32-bit words. Unfilled upper
// bytes of a partial word read as zero because the buffer is cleared per word.
module inst_mem_packer
  import inst_mem_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                clear_i,
  input  logic                accept_i,
  input  logic [BYTE_LEN-1:0] byte_i,
  output logic                word_valid_o,
  output logic [INST_LEN-1:0] word_o,
  output logic [INST_LEN-1:0] partial_word_o,
  output logic                pend_next_o
);

  logic [1:0]  lane_q;
  logic [23:0] buf_q;

  // Completed word bypasses the buffer so it can be written on the lane-3 edge.
  always_comb begin
    word_valid_o   = accept_i && (lane_q == 2'd3);
    word_o         = {byte_i, buf_q};
    partial_word_o = {8'h00, buf_q};
    pend_next_o    = accept_i ? (lane_q != 2'd3) : (lane_q != 2'd0);
  end

  // Lane counter and byte buffer.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      lane_q <= 2'd0;
      buf_q  <= '0;
    end else if (clear_i) begin
      lane_q <= 2'd0;
      buf_q  <= '0;
    end else if (accept_i) begin
      unique case (lane_q)
        2'd0: buf_q[7:0]   <= byte_i;
        2'd1: buf_q[15:8]  <= byte_i;
        2'd2: buf_q[23:16] <= byte_i;
        default: buf_q     <= '0;
      endcase
      lane_q <= lane_q + 2'd1;
    end
  end

endmodule

// File: rtl/inst_mem.sv
// Instruction memory: registered 1-cycle fetch port plus run-time byte loader.
// Optional feature macro: INST_MEM_MISALIGN_CHK_EN (misaligned fetch returns NOP
// and raises misalign_o).
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int unsigned          DEPTH_LOG2 = 10,
  parameter logic [INST_LEN-1:0]  NOP_INST   = NOP_INST_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  inst_mem_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PtrLast = '1;

  logic [INST_LEN-1:0]   mem [DEPTH];

  load_state_e           state_q;
  logic [DEPTH_LOG2-1:0] ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  ready_q;
  logic                  active_q;
  logic                  done_q;
  logic                  err_q;
  logic [INST_LEN-1:0]   rom_data_q;
  logic                  misalign_q;

  logic                  accept;
  logic                  pk_clear;
  logic                  word_valid;
  logic [INST_LEN-1:0]   word;
  logic [INST_LEN-1:0]   partial_word;
  logic                  pend_next;
  logic                  mem_we;
  logic [INST_LEN-1:0]   mem_wdata;

  assign accept   = bus.load_valid_i && ready_q;
  assign pk_clear = ((state_q == StIdle) && bus.load_start_i) || (state_q == StFlush);

  inst_mem_packer u_packer (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .clear_i        (pk_clear),
    .accept_i       (accept),
    .byte_i         (bus.load_byte_i),
    .word_valid_o   (word_valid),
    .word_o         (word),
    .partial_word_o (partial_word),
    .pend_next_o    (pend_next)
  );

  // Array write: full words while loading, the zero-padded tail in FLUSH.
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = word;
    if (state_q == StLoad) begin
      mem_we = word_valid;
    end else if (state_q == StFlush) begin
      mem_we    = 1'b1;
      mem_wdata = partial_word;
    end
  end

  // Array storage, deliberately not reset so a reset keeps loaded words.
  always_ff @(posedge clk_in) begin
    if (mem_we) begin
      mem[ptr_q] <= mem_wdata;
    end
  end

  // Loader FSM with registered status outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.load_start_i) begin
            state_q  <= StLoad;
            ptr_q    <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            active_q <= 1'b1;
          end
        end
        StLoad: begin
          if (word_valid) begin
            ptr_q   <= ptr_q + 1'b1;
            count_q <= count_q + 1'b1;
          end
          // A byte arriving with end is taken first, so end sees the updated lane.
          if (bus.load_end_i) begin
            ready_q <= 1'b0;
            if (pend_next) begin
              state_q <= StFlush;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end else if (word_valid && (ptr_q == PtrLast)) begin
            state_q <= StFull;
            ready_q <= 1'b0;
          end
        end
        StFlush: begin
          count_q <= count_q + 1'b1;
          state_q <= StDone;
          done_q  <= 1'b1;
        end
        StFull: begin
          if (bus.load_valid_i) begin
            err_q <= 1'b1;
          end
          if (bus.load_end_i) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q  <= StIdle;
          active_q <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          ready_q  <= 1'b0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  // Registered fetch port; image is not readable while a load is in flight.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rom_data_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      if (state_q != StIdle) begin
        rom_data_q <= NOP_INST;
      end else if (!bus.rom_ce_i) begin
        rom_data_q <= '0;
`ifdef INST_MEM_MISALIGN_CHK_EN
      end else if (bus.rom_addr_i[1:0] != 2'b00) begin
        rom_data_q <= NOP_INST;
        misalign_q <= 1'b1;
`endif
      end else if (bus.rom_addr_i[ADDR_LEN-1:DEPTH_LOG2+2] != '0) begin
        rom_data_q <= NOP_INST;
      end else begin
        rom_data_q <= mem[bus.rom_addr_i[DEPTH_LOG2+1:2]];
      end
    end
  end

`ifdef INST_MEM_MISALIGN_CHK_EN
  assign bus.misalign_o = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q ^ (^bus.rom_addr_i[1:0]);
`endif

  assign bus.rom_data_o    = rom_data_q;
  assign bus.load_ready_o  = ready_q;
  assign bus.load_active_o = active_q;
  assign bus.load_done_o   = done_q;
  assign bus.load_err_o    = err_q;
  assign bus.word_count_o  = count_q;

endmodule

// File: tb/tb_inst_mem.sv
// Directed bench for inst_mem, built with a 4-word array so overflow is cheap.
module tb_inst_mem;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  inst_mem_if #(.DEPTH_LOG2(2)) bus ();

  inst_mem #(.DEPTH_LOG2(2)) u_dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.load_valid_i = 1'b1;
    bus.load_byte_i  = b;
    step();
    bus.load_valid_i = 1'b0;
  endtask

  task automatic start_load();
    bus.load_start_i = 1'b1;
    step();
    bus.load_start_i = 1'b0;
  endtask

  task automatic end_load();
    bus.load_end_i = 1'b1;
    step();
    bus.load_end_i = 1'b0;
  endtask

  task automatic read_word(input logic [31:0] addr, input string tag, input logic [31:0] exp);
    bus.rom_ce_i   = 1'b1;
    bus.rom_addr_i = addr;
    step();
    check(tag, bus.rom_data_o, exp);
    bus.rom_ce_i   = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.rom_ce_i     = 1'b0;
    bus.rom_addr_i   = '0;
    bus.load_start_i = 1'b0;
    bus.load_valid_i = 1'b0;
    bus.load_byte_i  = '0;
    bus.load_end_i   = 1'b0;
    step();
    step();
    check("rst_data", bus.rom_data_o, 32'h0);
    check("rst_ready", 32'(bus.load_ready_o), 32'h0);
    check("rst_active", 32'(bus.load_active_o), 32'h0);
    rst = 1'b0;
    step();
    check("idle_done", 32'(bus.load_done_o), 32'h0);
    check("idle_err", 32'(bus.load_err_o), 32'h0);
    check("idle_count", 32'(bus.word_count_o), 32'h0);

    // Two full words
    start_load();
    check("ld_ready", 32'(bus.load_ready_o), 32'h1);
    check("ld_active", 32'(bus.load_active_o), 32'h1);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
    bus.load_start_i = 1'b1;  // must be ignored mid-load
    send_byte(8'h93);
    bus.load_start_i = 1'b0;
    send_byte(8'h05); send_byte(8'h20); send_byte(8'h00);
    end_load();
    check("full_done", 32'(bus.load_done_o), 32'h1);
    check("full_count", 32'(bus.word_count_o), 32'h2);
    check("full_ready_off", 32'(bus.load_ready_o), 32'h0);
    step();
    check("full_done_pulse", 32'(bus.load_done_o), 32'h0);
    check("full_inactive", 32'(bus.load_active_o), 32'h0);
    read_word(32'h4, "rd_w1", 32'h0020_0593);
    read_word(32'h0, "rd_w0", 32'h0010_0513);

    // Partial tail word: 5 bytes, flush pads with zeros
    start_load();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'hEF);
    end_load();
    check("part_no_done", 32'(bus.load_done_o), 32'h0);
    check("part_count_pre", 32'(bus.word_count_o), 32'h1);
    step();
    check("part_done", 32'(bus.load_done_o), 32'h1);
    check("part_count", 32'(bus.word_count_o), 32'h2);
    step();
    read_word(32'h4, "rd_part", 32'h0000_00EF);
    read_word(32'h0, "rd_part0", 32'h4433_2211);

    // Reads during a load, with ce low, and out of range
    start_load();
    read_word(32'h0, "rd_in_load", Nop);
    end_load();
    check("empty_done", 32'(bus.load_done_o), 32'h1);
    check("empty_count", 32'(bus.word_count_o), 32'h0);
    step();
    bus.rom_ce_i = 1'b0;
    step();
    check("rd_ce_low", bus.rom_data_o, 32'h0);
    read_word(32'h0001_0000, "rd_oor_hi", Nop);
    read_word(32'h0000_0010, "rd_oor_lo", Nop);
    read_word(32'h0, "rd_kept", 32'h4433_2211);

    // Overflow: 17 bytes into a 4-word array
    start_load();
    for (int k = 1; k <= 16; k++) begin
      send_byte(8'(k));
      if (k == 15) check("ovf_ready_15", 32'(bus.load_ready_o), 32'h1);
    end
    check("ovf_ready_16", 32'(bus.load_ready_o), 32'h0);
    check("ovf_count", 32'(bus.word_count_o), 32'h4);
    check("ovf_err_pre", 32'(bus.load_err_o), 32'h0);
    send_byte(8'h11);
    check("ovf_err", 32'(bus.load_err_o), 32'h1);
    check("ovf_count_hold", 32'(bus.word_count_o), 32'h4);
    end_load();
    check("ovf_done", 32'(bus.load_done_o), 32'h1);
    step();
    check("ovf_err_sticky", 32'(bus.load_err_o), 32'h1);
    read_word(32'h0, "ovf_w0", 32'h0403_0201);
    read_word(32'h4, "ovf_w1", 32'h0807_0605);
    read_word(32'h8, "ovf_w2", 32'h0C0B_0A09);
    read_word(32'hC, "ovf_w3", 32'h100F_0E0D);

    // Reset in the middle of a load
    start_load();
    check("ld2_err_clr", 32'(bus.load_err_o), 32'h0);
    check("ld2_count_clr", 32'(bus.word_count_o), 32'h0);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    send_byte(8'hB1);
    bus.rom_ce_i = 1'b1;
    bus.rom_addr_i = 32'h0;
    send_byte(8'hB2);
    check("mid_count", 32'(bus.word_count_o), 32'h1);
    check("mid_data_nop", bus.rom_data_o, Nop);
    bus.rom_ce_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_data", bus.rom_data_o, 32'h0);
    check("arst_ready", 32'(bus.load_ready_o), 32'h0);
    check("arst_active", 32'(bus.load_active_o), 32'h0);
    check("arst_count", 32'(bus.word_count_o), 32'h0);
    #1;
    rst = 1'b0;
    step();
    read_word(32'h0, "arst_w0", 32'hA4A3_A2A1);
    read_word(32'h4, "arst_w1", 32'h0807_0605);
`ifdef INST_MEM_MISALIGN_CHK_EN
    read_word(32'h2, "misal_data", Nop);
    check("misal_flag", 32'(bus.misalign_o), 32'h1);
    read_word(32'h0, "misal_clr_data", 32'hA4A3_A2A1);
    check("misal_clr_flag", 32'(bus.misalign_o), 32'h0);
`else
    read_word(32'h2, "addr_lsb_ignored", 32'hA4A3_A2A1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
